// File: rtl/top_simon_dec.sv
// ---------------------------------------------------------------------------
// top_simon_dec
// Simon 128/128 decryption core (inverse of the team's Simon encryption top).
//
// An accepted start latches a 128-bit ciphertext and a 128-bit master key.
// The core then expands the key forward to (k66,k67) in KEYEXP, which takes
// 66 cycles. Next it runs 68 inverse rounds in DECRYPT. During those rounds
// it rebuilds each earlier round key with the inverse key schedule, so no
// round-key storage is needed.
//
// Ports
//   clk      in   1    clock, rising edge
//   rst      in   1    asynchronous reset, active-high
//   start_i  in   1    start request, sampled only in IDLE
//   ct_i     in   128  ciphertext, [127:64]=x, [63:0]=y
//   k0_i     in   128  master key, [127:64]=k1, [63:0]=k0
//   busy_o   out  1    high in KEYEXP / DECRYPT / DONE
//   valid_o  out  1    pt_o holds a result; sticky until the next accepted start
//   pt_o     out  128  plaintext, [127:64]=x, [63:0]=y
//
// Configuration macro: SIMON_DEC_KEYCACHE_EN
//   When defined, a one-entry cache remembers (k66,k67) for the last expanded
//   master key. A start with that key skips KEYEXP (latency 69 instead of 135).
// ---------------------------------------------------------------------------
module top_simon_dec (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [127:0] ct_i,
  input  logic [127:0] k0_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [127:0] pt_o
);

  localparam int          ROUNDS    = 68;
  localparam logic [63:0] KEY_CONST = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [61:0] Z_SEQ     =
    62'b10101111011100000011010010011000101000010001111110010110110011;

  localparam logic [3:0] S_IDLE    = 4'b0001;
  localparam logic [3:0] S_KEYEXP  = 4'b0010;
  localparam logic [3:0] S_DECRYPT = 4'b0100;
  localparam logic [3:0] S_DONE    = 4'b1000;

  logic [3:0]  state;
  logic [63:0] x, y, ka, kb;
  // Step index: counts i up in KEYEXP and round r down in DECRYPT
  logic [6:0]  cnt;

  logic [6:0]  zsel;
  logic [5:0]  zidx;
  logic [63:0] zword;
  logic [63:0] fwd_kb;
  logic [63:0] inv_ka;
  logic [63:0] f_y;
  logic [63:0] y_next;

`ifdef SIMON_DEC_KEYCACHE_EN
  logic         cache_vld;
  logic [127:0] cache_key;
  logic [127:0] cache_k;
  logic         hit;

  assign hit = cache_vld && (k0_i == cache_key);
`endif

  assign busy_o = (state != S_IDLE);

  // z index: i in KEYEXP, r-2 in DECRYPT, reduced mod 62.
  // z[0] is the leftmost (MSB) bit of Z_SEQ.
  always_comb begin
    zsel  = (state == S_DECRYPT) ? cnt - 7'd2 : cnt;
    zidx  = (zsel >= 7'd62) ? 6'(zsel - 7'd62) : 6'(zsel);
    zword = {63'd0, Z_SEQ[6'd61 - zidx]};
  end

  // Forward key step k_{i+2} from (k_i, k_{i+1}) = (ka, kb).
  // The inverse step recovers k_{r-2} from (k_{r-1}, k_r) = (ka, kb).
  always_comb begin
    fwd_kb = KEY_CONST ^ zword ^ ka ^ {kb[2:0], kb[63:3]} ^ {kb[3:0], kb[63:4]};
    inv_ka = kb ^ KEY_CONST ^ zword ^ {ka[2:0], ka[63:3]} ^ {ka[3:0], ka[63:4]};
  end

  // Inverse round: f(y) = (rol1(y) & rol8(y)) ^ rol2(y)
  always_comb begin
    f_y    = ({y[62:0], y[63]} & {y[55:0], y[63:56]}) ^ {y[61:0], y[63:62]};
    y_next = x ^ f_y ^ kb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      x       <= '0;
      y       <= '0;
      ka      <= '0;
      kb      <= '0;
      cnt     <= '0;
      valid_o <= 1'b0;
      pt_o    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            x       <= ct_i[127:64];
            y       <= ct_i[63:0];
            valid_o <= 1'b0;
`ifdef SIMON_DEC_KEYCACHE_EN
            if (hit) begin
              kb    <= cache_k[127:64];
              ka    <= cache_k[63:0];
              cnt   <= 7'(ROUNDS - 1);
              state <= S_DECRYPT;
            end else begin
              ka    <= k0_i[63:0];
              kb    <= k0_i[127:64];
              cnt   <= '0;
              state <= S_KEYEXP;
            end
`else
            ka    <= k0_i[63:0];
            kb    <= k0_i[127:64];
            cnt   <= '0;
            state <= S_KEYEXP;
`endif
          end
        end

        S_KEYEXP: begin
          ka <= kb;
          kb <= fwd_kb;
          if (cnt == 7'd65) begin
            cnt   <= 7'(ROUNDS - 1);
            state <= S_DECRYPT;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end

        S_DECRYPT: begin
          x <= y;
          y <= y_next;
          // After round 1 only k0 is still needed, so ka is cleared rather than
          // running the inverse schedule past k0.
          if (cnt >= 7'd2) begin
            ka <= inv_ka;
            kb <= ka;
          end else if (cnt == 7'd1) begin
            ka <= '0;
            kb <= ka;
          end
          if (cnt == 7'd0) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt - 7'd1;
          end
        end

        S_DONE: begin
          pt_o    <= {x, y};
          valid_o <= 1'b1;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SIMON_DEC_KEYCACHE_EN
  // The key is captured on a miss, while the entry is invalidated. The entry
  // becomes valid only when (k66,k67) lands at the end of KEYEXP. An aborted
  // expansion therefore never leaves a half-built entry behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_vld <= 1'b0;
      cache_key <= '0;
      cache_k   <= '0;
    end else if (state == S_IDLE && start_i && !hit) begin
      cache_vld <= 1'b0;
      cache_key <= k0_i;
    end else if (state == S_KEYEXP && cnt == 7'd65) begin
      cache_vld <= 1'b1;
      cache_k   <= {fwd_kb, kb};
    end
  end
`endif

endmodule

// File: tb/tb_top_simon_dec.sv
// ---------------------------------------------------------------------------
// tb_top_simon_dec
// Directed bench for top_simon_dec.
//
// A small Simon 128/128 model (forward key expansion, encrypt, decrypt)
// supplies the expected plaintexts for the round-trip vectors. It also
// supplies the expected plaintext for the modified-key vector. The published
// vector is checked against hand-copied constants.
//
// Define SIMON_DEC_KEYCACHE_EN for both the bench and the RTL to check
// the cached-key latency.
// ---------------------------------------------------------------------------
module tb_top_simon_dec;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [127:0] ct_i;
  logic [127:0] k0_i;
  logic         busy_o;
  logic         valid_o;
  logic [127:0] pt_o;

  int vec_count = 0;
  int err_count = 0;

  logic [61:0]  z_seq = 62'b10101111011100000011010010011000101000010001111110010110110011;
  logic [63:0]  rk [0:67];

  // Bench-side picture of the DUT key cache
  logic         m_cache_vld = 1'b0;
  logic [127:0] m_cache_key = '0;

  // Published vector. ct and pt are {x,y}; the key is {k1,k0}.
  localparam logic [127:0] V1_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] V1_CT  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
  localparam logic [127:0] V1_PT  = 128'h6373656420737265_6c6c657661727420;

  top_simon_dec dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .ct_i    (ct_i),
    .k0_i    (k0_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .pt_o    (pt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [63:0] rol(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [63:0] fr(input logic [63:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  // Reference key schedule: tmp = ror3(k[i+1]); tmp ^= ror1(tmp);
  // k[i+2] = ~k[i] ^ tmp ^ z ^ 3
  function automatic void model_expand(input logic [127:0] key);
    logic [63:0] tmp;
    rk[0] = key[63:0];
    rk[1] = key[127:64];
    for (int i = 0; i < 66; i++) begin
      tmp = ror(rk[i+1], 3);
      tmp = tmp ^ ror(tmp, 1);
      rk[i+2] = ~rk[i] ^ tmp ^ {63'd0, z_seq[61 - (i % 62)]} ^ 64'd3;
    end
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt);
    logic [63:0] x, y, t;
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 68; i++) begin
      t = x;
      x = y ^ fr(x) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [63:0] x, y, t;
    x = ct[127:64];
    y = ct[63:0];
    for (int i = 67; i >= 0; i--) begin
      t = y;
      y = x ^ fr(y) ^ rk[i];
      x = t;
    end
    return {x, y};
  endfunction

  function automatic int exp_latency(input logic [127:0] key);
`ifdef SIMON_DEC_KEYCACHE_EN
    return (m_cache_vld && key == m_cache_key) ? 69 : 135;
`else
    return 135;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vec_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Starts one decryption from the posedge+1 phase and waits for valid_o.
  // Optional pulses re-raise start_i (with a different ct_i) so that it is
  // sampled at edges p1 and p2 after the accepting edge.
  task automatic applyStimulus(input string tag, input logic [127:0] ct,
                               input logic [127:0] key, input logic [127:0] exp_pt,
                               input int p1, input int p2);
    int lat;
    int want;
    want    = exp_latency(key);
    ct_i    = ct;
    k0_i    = key;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    checkOutput({tag, "_vldclr"}, 128'(valid_o), 128'(0));
    checkOutput({tag, "_busy"},   128'(busy_o),  128'(1));
    lat = 0;
    for (int n = 1; n <= 300 && lat == 0; n++) begin
      if (n == p1 || n == p2) begin
        start_i = 1'b1;
        ct_i    = ~ct;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      ct_i    = ct;
      if (valid_o) lat = n;
    end
    checkOutput({tag, "_lat"},  128'(lat), 128'(want));
    checkOutput({tag, "_pt"},   pt_o, exp_pt);
    checkOutput({tag, "_idle"}, 128'(busy_o), 128'(0));
    if (want == 135) begin
      m_cache_vld = 1'b1;
      m_cache_key = key;
    end
  endtask

  initial begin
    logic [127:0] key2, pt2, key, pt, ct;

    rst     = 1'b1;
    start_i = 1'b0;
    ct_i    = '0;
    k0_i    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy",  128'(busy_o),  128'(0));
    checkOutput("rst_valid", 128'(valid_o), 128'(0));
    checkOutput("rst_pt",    pt_o,          128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Published vector
    applyStimulus("v1", V1_CT, V1_KEY, V1_PT, 0, 0);

    // Same key again, then the key with a single bit flipped
    applyStimulus("v1_again", V1_CT, V1_KEY, V1_PT, 0, 0);
    key2 = V1_KEY ^ (128'd1 << 37);
    model_expand(key2);
    pt2 = model_dec(V1_CT);
    applyStimulus("keyflip", V1_CT, key2, pt2, 0, 0);

    // start_i pulses while busy must be ignored
    applyStimulus("ignore", V1_CT, V1_KEY, V1_PT, 30, 100);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("ignore_busy", 128'(busy_o), 128'(0));
    checkOutput("ignore_pt",   pt_o,         V1_PT);

    // Abort in DECRYPT. A different key forces KEYEXP in both builds.
    ct_i    = V1_CT;
    k0_i    = key2;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (89) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy",  128'(busy_o),  128'(0));
    checkOutput("abort_valid", 128'(valid_o), 128'(0));
    checkOutput("abort_pt",    pt_o,          128'(0));
    m_cache_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus("after_rst", V1_CT, V1_KEY, V1_PT, 0, 0);

    // valid_o holds across idle cycles
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checkOutput("sticky", 128'(valid_o), 128'(1));
    end

    // Round trips through the model encryptor
    for (int t = 0; t < 203; t++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      if (t == 0) key = '0;
      if (t == 1) key = '1;
      if (t == 2) pt  = '0;
      model_expand(key);
      ct = model_enc(pt);
      applyStimulus("rt", ct, key, pt, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
